// File: rtl/square_obj_pkg.sv
// Shared types and constants for the multi-channel square object bank.
package square_obj_pkg;

    localparam int COORD_W = 11;
    localparam int SIZE_W  = 3;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    // One object channel: enable flag, top-left corner and size shift.
    typedef struct packed {
        logic               active;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SIZE_W-1:0]  size;
    } obj_entry_t;

    // Limits a requested size shift to the largest shift the bank supports.
    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] s,
                                                     input int max_size);
        if (int'(s) > max_size) begin
            return SIZE_W'(max_size);
        end
        return s;
    endfunction

endpackage

// File: rtl/square_hit_test.sv
// Bracket compare and offset computation for a single object channel.
// Extents are formed one bit wider than the coordinates, so an object
// hanging past x=2047 is clipped at the edge of the screen and never
// wraps around to x=0.
module square_hit_test
    import square_obj_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = 8,
    parameter int OBJECT_HEIGHT_Y = 8
) (
    input  obj_entry_t         entry,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    output logic               hit,
    output logic [COORD_W-1:0] offset_x,
    output logic [COORD_W-1:0] offset_y
);

    logic [COORD_W:0] width_ext;
    logic [COORD_W:0] height_ext;
    logic [COORD_W:0] right_x;
    logic [COORD_W:0] bottom_y;

    // Compute the extents of the object and test the pixel against them.
    always_comb begin
        width_ext  = (COORD_W+1)'(OBJECT_WIDTH_X)  << entry.size;
        height_ext = (COORD_W+1)'(OBJECT_HEIGHT_Y) << entry.size;
        right_x    = {1'b0, entry.x} + width_ext;
        bottom_y   = {1'b0, entry.y} + height_ext;
        hit        = entry.active
                     && (pixel_x >= entry.x) && ({1'b0, pixel_x} < right_x)
                     && (pixel_y >= entry.y) && ({1'b0, pixel_y} < bottom_y);
        offset_x   = pixel_x - entry.x;
        offset_y   = pixel_y - entry.y;
    end

endmodule

// File: rtl/multi_square_object_bank.sv
// Bank of NUM_OBJ square objects with a double-buffered position/size
// table. Writes land in the shadow bank; startOfFrame copies it into the
// active bank. Each pixel passes through a two-stage pipeline: per-channel
// hit test, then a lowest-index priority pick.
module multi_square_object_bank
    import square_obj_pkg::*;
#(
    parameter int         NUM_OBJ         = 8,
    parameter int         OBJECT_WIDTH_X  = 8,
    parameter int         OBJECT_HEIGHT_Y = 8,
    parameter int         MAX_SIZE        = 4,
    parameter logic [7:0] OBJECT_COLOR    = 8'h5b,
    localparam int        IDX_W           = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_topLeftX,
    input  logic [COORD_W-1:0] wr_topLeftY,
    input  logic [SIZE_W-1:0]  wr_size,
    input  logic               wr_active,
    output logic               drawingRequest,
    output logic [IDX_W-1:0]   hitIndex,
    output logic [COORD_W-1:0] offsetX,
    output logic [COORD_W-1:0] offsetY,
    output logic [SIZE_W-1:0]  size_out,
    output logic [7:0]         RGBout
);

    obj_entry_t shadow     [NUM_OBJ];
    obj_entry_t active     [NUM_OBJ];
    obj_entry_t commit_val [NUM_OBJ];
    obj_entry_t eval_val   [NUM_OBJ];
    obj_entry_t wr_entry;
    logic       wr_valid;

    logic [NUM_OBJ-1:0] hit_c;
    logic [COORD_W-1:0] off_x_c [NUM_OBJ];
    logic [COORD_W-1:0] off_y_c [NUM_OBJ];

    logic [NUM_OBJ-1:0] hit_q;
    logic [COORD_W-1:0] off_x_q [NUM_OBJ];
    logic [COORD_W-1:0] off_y_q [NUM_OBJ];
    logic [SIZE_W-1:0]  size_q  [NUM_OBJ];

    logic               any_hit;
    logic [IDX_W-1:0]   sel_idx;

    // Assemble the incoming write; out-of-range channel numbers are dropped.
    always_comb begin
        wr_entry.active = wr_active;
        wr_entry.x      = wr_topLeftX;
        wr_entry.y      = wr_topLeftY;
        wr_entry.size   = clamp_size(wr_size, MAX_SIZE);
        wr_valid        = wr_en && (int'(wr_idx) < NUM_OBJ);
    end

    // Value each channel takes at a commit (write-through for the channel
    // being written this cycle), and the value the hit test uses: a pixel
    // sampled on the commit edge already sees the new bank.
    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            commit_val[i] = (wr_valid && (wr_idx == IDX_W'(i))) ? wr_entry : shadow[i];
            eval_val[i]   = startOfFrame ? commit_val[i] : active[i];
        end
    end

    // Shadow bank: takes register writes at any time.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_OBJ; i++) shadow[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (wr_valid && (wr_idx == IDX_W'(i))) shadow[i] <= wr_entry;
            end
        end
    end

    // Active bank: updated only at the frame boundary.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_OBJ; i++) active[i] <= '0;
        end else if (startOfFrame) begin
            for (int i = 0; i < NUM_OBJ; i++) active[i] <= commit_val[i];
        end
    end

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
        square_hit_test #(
            .OBJECT_WIDTH_X  (OBJECT_WIDTH_X),
            .OBJECT_HEIGHT_Y (OBJECT_HEIGHT_Y)
        ) u_hit (
            .entry    (eval_val[g]),
            .pixel_x  (pixelX),
            .pixel_y  (pixelY),
            .hit      (hit_c[g]),
            .offset_x (off_x_c[g]),
            .offset_y (off_y_c[g])
        );
    end

    // Stage 1: register per-channel hit flags, offsets and sizes.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_q <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                off_x_q[i] <= '0;
                off_y_q[i] <= '0;
                size_q[i]  <= '0;
            end
        end else begin
            hit_q <= hit_c;
            for (int i = 0; i < NUM_OBJ; i++) begin
                off_x_q[i] <= off_x_c[i];
                off_y_q[i] <= off_y_c[i];
                size_q[i]  <= eval_val[i].size;
            end
        end
    end

    // Priority pick: scanning downward leaves the lowest hit index selected.
    always_comb begin
        any_hit = 1'b0;
        sel_idx = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                any_hit = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Stage 2: register the selected channel's results onto the outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drawingRequest <= 1'b0;
            hitIndex       <= '0;
            offsetX        <= '0;
            offsetY        <= '0;
            size_out       <= '0;
            RGBout         <= TRANSPARENT_ENCODING;
        end else if (any_hit) begin
            drawingRequest <= 1'b1;
            hitIndex       <= sel_idx;
            offsetX        <= off_x_q[sel_idx];
            offsetY        <= off_y_q[sel_idx];
            size_out       <= size_q[sel_idx];
            RGBout         <= OBJECT_COLOR;
        end else begin
            drawingRequest <= 1'b0;
            hitIndex       <= '0;
            offsetX        <= '0;
            offsetY        <= '0;
            size_out       <= '0;
            RGBout         <= TRANSPARENT_ENCODING;
        end
    end

endmodule

// File: tb/tb_multi_square_object_bank.sv
// Table-driven bench for multi_square_object_bank with a two-deep
// expectation queue matching the pixel pipeline latency.
module tb_multi_square_object_bank;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic [10:0] wr_topLeftX = '0;
    logic [10:0] wr_topLeftY = '0;
    logic [2:0]  wr_size = '0;
    logic        wr_active = 1'b0;
    logic        drawingRequest;
    logic [2:0]  hitIndex;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [2:0]  size_out;
    logic [7:0]  RGBout;

    multi_square_object_bank dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .wr_en          (wr_en),
        .wr_idx         (wr_idx),
        .wr_topLeftX    (wr_topLeftX),
        .wr_topLeftY    (wr_topLeftY),
        .wr_size        (wr_size),
        .wr_active      (wr_active),
        .drawingRequest (drawingRequest),
        .hitIndex       (hitIndex),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .size_out       (size_out),
        .RGBout         (RGBout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic        dr;
        logic [2:0]  idx;
        logic [10:0] ox;
        logic [10:0] oy;
        logic [2:0]  sz;
        logic [7:0]  rgb;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  wi;
        logic [10:0] wx;
        logic [10:0] wy;
        logic [2:0]  ws;
        logic        wa;
        logic        sof;
        logic [10:0] px;
        logic [10:0] py;
        exp_t        e;
    } vec_t;

    exp_t  exp_q[$];
    string name_q[$];
    vec_t  vecs[$];
    int    total = 0;
    int    bad = 0;

    function automatic exp_t hit(input int idx, input int ox, input int oy, input int sz);
        exp_t r;
        r.chk = 1'b1; r.dr = 1'b1; r.idx = 3'(idx);
        r.ox = 11'(ox); r.oy = 11'(oy); r.sz = 3'(sz); r.rgb = 8'h5b;
        return r;
    endfunction

    function automatic exp_t miss();
        exp_t r;
        r = '0;
        r.chk = 1'b1; r.rgb = 8'hFF;
        return r;
    endfunction

    function automatic exp_t dc();
        exp_t r;
        r = '0;
        return r;
    endfunction

    function automatic vec_t mk(input int we, input int wi, input int wx, input int wy,
                                input int ws, input int wa, input int sof,
                                input int px, input int py, input exp_t e);
        vec_t v;
        v.we = (we != 0); v.wi = 3'(wi); v.wx = 11'(wx); v.wy = 11'(wy);
        v.ws = 3'(ws); v.wa = (wa != 0); v.sof = (sof != 0);
        v.px = 11'(px); v.py = 11'(py); v.e = e;
        return v;
    endfunction

    function automatic vec_t pix(input int px, input int py, input exp_t e);
        return mk(0, 0, 0, 0, 0, 0, 0, px, py, e);
    endfunction

    task automatic check_out(input exp_t e, input string name);
        total++;
        if ({drawingRequest, hitIndex, offsetX, offsetY, size_out, RGBout} !==
            {e.dr, e.idx, e.ox, e.oy, e.sz, e.rgb}) begin
            bad++;
            $display("FAIL %s: got dr=%0b idx=%0d off=(%0d,%0d) size=%0d rgb=%h, want dr=%0b idx=%0d off=(%0d,%0d) size=%0d rgb=%h",
                     name, drawingRequest, hitIndex, offsetX, offsetY, size_out, RGBout,
                     e.dr, e.idx, e.ox, e.oy, e.sz, e.rgb);
        end
    endtask

    // One pipeline step: retire the result of the pixel driven two cycles
    // ago, then drive this cycle's pixel and controls.
    task automatic tick(input vec_t v, input string name);
        exp_t  ex;
        string nm;
        @(negedge clk);
        if (exp_q.size() == 2) begin
            ex = exp_q.pop_front();
            nm = name_q.pop_front();
            if (ex.chk) check_out(ex, nm);
        end
        pixelX       = v.px;
        pixelY       = v.py;
        wr_en        = v.we;
        wr_idx       = v.wi;
        wr_topLeftX  = v.wx;
        wr_topLeftY  = v.wy;
        wr_size      = v.ws;
        wr_active    = v.wa;
        startOfFrame = v.sof;
        exp_q.push_back(v.e);
        name_q.push_back(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Baseline: nothing active.
        vecs.push_back(pix(100, 50, miss()));
        vecs.push_back(pix(0, 0, miss()));
        // ch0 written; not visible before the commit.
        vecs.push_back(mk(1, 0, 100, 50, 1, 1, 0, 100, 50, miss()));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, dc()));
        vecs.push_back(pix(100, 50, hit(0, 0, 0, 1)));
        vecs.push_back(pix(115, 65, hit(0, 15, 15, 1)));
        vecs.push_back(pix(116, 50, miss()));
        vecs.push_back(pix(100, 66, miss()));
        vecs.push_back(pix(99, 50, miss()));
        // Overlap of ch2 (196..203) and ch5 (200..231).
        vecs.push_back(mk(1, 2, 196, 196, 0, 1, 0, 0, 0, dc()));
        vecs.push_back(mk(1, 5, 200, 200, 2, 1, 0, 0, 0, dc()));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, dc()));
        vecs.push_back(pix(200, 200, hit(2, 4, 4, 0)));
        vecs.push_back(pix(210, 210, hit(5, 10, 10, 2)));
        vecs.push_back(pix(203, 203, hit(2, 7, 7, 0)));
        vecs.push_back(pix(204, 204, hit(5, 4, 4, 2)));
        // Deactivate ch2: takes effect only after the commit.
        vecs.push_back(mk(1, 2, 196, 196, 0, 0, 0, 0, 0, dc()));
        vecs.push_back(pix(200, 200, hit(2, 4, 4, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, dc()));
        vecs.push_back(pix(200, 200, hit(5, 0, 0, 2)));
        // Move ch0 without commit, then commit.
        vecs.push_back(mk(1, 0, 300, 50, 1, 1, 0, 0, 0, dc()));
        vecs.push_back(pix(100, 50, hit(0, 0, 0, 1)));
        vecs.push_back(pix(300, 50, miss()));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, dc()));
        vecs.push_back(pix(100, 50, miss()));
        vecs.push_back(pix(300, 50, hit(0, 0, 0, 1)));
        // Size clamp 7 -> 4 and clipping at the right screen edge.
        vecs.push_back(mk(1, 1, 2000, 0, 7, 1, 0, 0, 0, dc()));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, dc()));
        vecs.push_back(pix(2047, 10, hit(1, 47, 10, 4)));
        vecs.push_back(pix(0, 10, miss()));
        vecs.push_back(pix(1999, 10, miss()));
        vecs.push_back(pix(2000, 127, hit(1, 0, 127, 4)));
        vecs.push_back(pix(2000, 128, miss()));
        // Write and commit in the same cycle.
        vecs.push_back(mk(1, 3, 400, 400, 0, 1, 1, 0, 0, dc()));
        vecs.push_back(pix(400, 400, hit(3, 0, 0, 0)));
        vecs.push_back(pix(407, 407, hit(3, 7, 7, 0)));
        vecs.push_back(pix(408, 400, miss()));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, dc()));
        vecs.push_back(pix(404, 404, hit(3, 4, 4, 0)));

        // Reset state.
        #12;
        check_out(miss(), "reset_state");
        @(negedge clk);
        resetN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i], $sformatf("vec%0d", i));
        end

        // Keep ch3 hitting so the asynchronous reset has something to clear.
        tick(pix(400, 400, hit(3, 0, 0, 0)), "pre_rst_a");
        tick(pix(400, 400, hit(3, 0, 0, 0)), "pre_rst_b");
        tick(pix(400, 400, hit(3, 0, 0, 0)), "pre_rst_c");
        @(posedge clk);
        #2;
        check_out(hit(3, 0, 0, 0), "pre_rst_out");
        resetN = 1'b0;
        #1;
        check_out(miss(), "async_reset");
        exp_q.delete();
        name_q.delete();
        @(negedge clk);
        resetN = 1'b1;

        // After reset nothing draws, even across a commit of the cleared shadow.
        tick(pix(400, 400, miss()), "post_rst_a");
        tick(mk(0, 0, 0, 0, 0, 0, 1, 400, 400, miss()), "post_rst_sof");
        tick(pix(400, 400, miss()), "post_rst_b");
        tick(pix(200, 200, miss()), "post_rst_c");
        tick(pix(0, 0, dc()), "flush_a");
        tick(pix(0, 0, dc()), "flush_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_square_object_bank.md
Name: multi_square_object_bank

Overview:
- Parametrised, multi-channel successor of the single adjustable-size square object.
- Holds NUM_OBJ independent square brackets (balls), each with its own position, size shift and active flag.
- Positions and sizes are double-buffered and applied only on startOfFrame, so the image never tears.
- Per pixel, it reports whether any active object covers the pixel, the lowest-index hit, and the offset into that object. It feeds the bitmap/ROM stage and the draw-priority mux.

Parameters:
- NUM_OBJ, 8: number of object channels (1..16).
- OBJECT_WIDTH_X, 8: base width in pixels at size 0.
- OBJECT_HEIGHT_Y, 8: base height in pixels at size 0.
- MAX_SIZE, 4: largest legal size shift; larger writes are clamped to this value.
- OBJECT_COLOR, 8'h5b: RGB value driven on a hit.

Ports:
- clk  in  1  clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse; copies the shadow bank into the active bank
- pixelX  in  11  current VGA pixel X
- pixelY  in  11  current VGA pixel Y
- wr_en  in  1  write strobe for the shadow bank
- wr_idx  in  $clog2(NUM_OBJ)  channel to write
- wr_topLeftX  in  11  new top-left X
- wr_topLeftY  in  11  new top-left Y
- wr_size  in  3  new size shift
- wr_active  in  1  new enable flag for the channel
- drawingRequest  out  1  pixel is inside at least one active object
- hitIndex  out  $clog2(NUM_OBJ)  lowest-index object hit
- offsetX  out  11  pixelX minus topLeftX of the hit object
- offsetY  out  11  pixelY minus topLeftY of the hit object
- size_out  out  3  active size of the hit object
- RGBout  out  8  OBJECT_COLOR on a hit, 8'hFF otherwise

Behaviour:
- Reset is resetN, asynchronous, active-low; clock is clk.
- Reset values:
  - All shadow and active channels: active=0, topLeftX=0, topLeftY=0, size=0.
  - Pipeline registers cleared.
  - drawingRequest=0, hitIndex=0, offsetX=0, offsetY=0, size_out=0, RGBout=8'hFF.
- Shadow write:
  - On a clk edge with wr_en=1, shadow[wr_idx] takes the four wr_* values.
  - Size is stored as min(wr_size, MAX_SIZE).
  - wr_idx >= NUM_OBJ: write ignored.
- Frame commit:
  - On a clk edge with startOfFrame=1, active[i] <= shadow[i] for all i.
  - If wr_en and startOfFrame fall in the same cycle, the written channel's new value lands in both shadow and active (write-through).
- Extents:
  - rightX = topLeftX + (OBJECT_WIDTH_X << size); bottomY = topLeftY + (OBJECT_HEIGHT_Y << size).
  - Computed in 12 bits, so there is no wrap. An object crossing x=2047 is clipped at the screen limit and never wraps to x=0.
- Stage 1 (registered), per channel i:
  - hit[i] = active[i] && pixelX>=topLeftX && pixelX<rightX && pixelY>=topLeftY && pixelY<bottomY.
  - Per-channel offsets and sizes are registered alongside hit[i].
- Stage 2 (registered):
  - Priority encoder selects the lowest i with hit[i]=1 and drives that channel's offsetX, offsetY and size_out, with hitIndex=i, drawingRequest=1, RGBout=OBJECT_COLOR.
  - No hit: drawingRequest=0, offsets=0, size_out=0, hitIndex=0, RGBout=8'hFF.
- Latency: exactly 2 clk from a pixelX/pixelY sample to its outputs, with no bubbles. The pixel-generator alignment must be compensated downstream.
- Active-bank changes affect pixels sampled on or after the commit edge. In-flight pixels use the values they were evaluated with.
- Reset mid-frame: outputs drop to reset values immediately; nothing draws until a later write plus startOfFrame.
- Zero-size object: impossible, since the minimum extent is the base size.

Decomposition:
- Package square_obj_pkg:
  - typedef obj_entry_t {logic active; logic [10:0] x, y; logic [2:0] size;}
  - TRANSPARENT_ENCODING = 8'hFF
  - COORD_W = 11
- Sub-module square_hit_test: one channel's bracket compare and offset computation. It is combinational and instantiated NUM_OBJ times via generate.
- The priority encoder stays inline.

Test Plan:
- Reset, then any pixel -> drawingRequest=0, RGBout=8'hFF, all outputs 0.
- Write ch0 (x=100, y=50, size=1, active) then startOfFrame; sample pixel (100,50) -> 2 clk later drawingRequest=1, offset (0,0), size_out=1. Pixel (115,65) hits with offset (15,15); pixel (116,50) misses.
- Channels 2 and 5 overlap at (200,200) -> hitIndex=2. Deactivate ch2 and commit -> hitIndex=5.
- Write ch0 to x=300 without startOfFrame -> pixel (100,50) still hits. After startOfFrame it misses and (300,50) hits.
- wr_size=7 with MAX_SIZE=4 -> size_out=4, extent 128. Object at x=2000 with size 4 -> pixel 2047 hits; pixelX=0 never hits from wrap.
- wr_en and startOfFrame in the same cycle -> new value visible on the next sample. resetN pulsed mid-frame -> outputs at reset values asynchronously.
